// File: rtl/registro_decodificacion.sv
// registro_decodificacion: 2-entry skid buffer between fetch and the immediate decoder, with registered RV32I immediate-type decode.
// Optional transfer counter on num_inst when REGISTRO_DECODIFICACION_CONTADOR_EN is defined.
module registro_decodificacion #(
  parameter int          ANCHO_PC = 32,
  parameter logic [31:0] INST_NOP = 32'h00000013
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valido_ent,
  output logic                listo_ent,
  input  logic [31:0]         inst_ent,
  input  logic [ANCHO_PC-1:0] pc_ent,
  input  logic                vaciar,
  output logic                valido_sal,
  input  logic                listo_sal,
  output logic [31:0]         inst_sal,
  output logic [ANCHO_PC-1:0] pc_sal,
  output logic [2:0]          tipo,
  output logic                usa_inmediato,
`ifdef REGISTRO_DECODIFICACION_CONTADOR_EN
  output logic [31:0]         num_inst,
`endif
  output logic                ilegal
);
  typedef struct packed {
    logic [31:0]         inst;
    logic [ANCHO_PC-1:0] pc;
    logic [2:0]          tipo;
    logic                usa;
    logic                ilegal;
  } entrada_t;
  localparam entrada_t VACIA = {INST_NOP, {(ANCHO_PC+5){1'b0}}};
  entrada_t ent, sal, skid;
  logic skid_v, in_xfer, out_xfer, carga_sal;
  assign in_xfer   = valido_ent & listo_ent;
  assign out_xfer  = valido_sal & listo_sal;
  assign carga_sal = !valido_sal | listo_sal;
  always_comb begin
    ent.inst   = inst_ent;
    ent.pc     = pc_ent;
    ent.tipo   = 3'b000;
    ent.usa    = 1'b1;
    ent.ilegal = 1'b0;
    case (inst_ent[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011: ent.tipo = 3'b000;
      7'b0100011: ent.tipo = 3'b001;
      7'b1100011: ent.tipo = 3'b010;
      7'b0110111, 7'b0010111: ent.tipo = 3'b011;
      7'b1101111: ent.tipo = 3'b100;
      7'b0110011: ent.usa = 1'b0;
      default: begin
        ent.usa    = 1'b0;
        ent.ilegal = 1'b1;
      end
    endcase
  end
  // Skid is only ever full while the output is valid, so listo_ent == !skid_v outside reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valido_sal <= 1'b0;
      skid_v     <= 1'b0;
      listo_ent  <= 1'b0;
      sal        <= VACIA;
    end else if (vaciar) begin
      valido_sal <= 1'b0;
      skid_v     <= 1'b0;
      listo_ent  <= 1'b1;
      sal        <= VACIA;
    end else if (carga_sal) begin
      valido_sal <= skid_v | in_xfer;
      sal        <= skid_v ? skid : (in_xfer ? ent : sal);
      skid_v     <= 1'b0;
      listo_ent  <= 1'b1;
    end else if (in_xfer) begin
      skid       <= ent;
      skid_v     <= 1'b1;
      listo_ent  <= 1'b0;
    end
  end
  assign inst_sal      = sal.inst;
  assign pc_sal        = sal.pc;
  assign tipo          = sal.tipo;
  assign usa_inmediato = sal.usa;
  assign ilegal        = sal.ilegal;
`ifdef REGISTRO_DECODIFICACION_CONTADOR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) num_inst <= '0;
    else if (out_xfer) num_inst <= num_inst + 32'd1;
  end
`endif
endmodule

// File: tb/tb_registro_decodificacion.sv
// tb_registro_decodificacion: scoreboard bench for registro_decodificacion (optionally with REGISTRO_DECODIFICACION_CONTADOR_EN).
module tb_registro_decodificacion;
  logic clk = 0, rst_n = 0, valido_ent = 0, vaciar = 0, listo_sal = 0;
  logic [31:0] inst_ent = 0, pc_ent = 0;
  logic listo_ent, valido_sal, usa_inmediato, ilegal;
  logic [31:0] inst_sal, pc_sal;
  logic [2:0] tipo;
`ifdef REGISTRO_DECODIFICACION_CONTADOR_EN
  logic [31:0] num_inst;
`endif
  registro_decodificacion dut (
    .clk(clk), .rst_n(rst_n), .valido_ent(valido_ent), .listo_ent(listo_ent),
    .inst_ent(inst_ent), .pc_ent(pc_ent), .vaciar(vaciar), .valido_sal(valido_sal),
    .listo_sal(listo_sal), .inst_sal(inst_sal), .pc_sal(pc_sal), .tipo(tipo),
    .usa_inmediato(usa_inmediato),
`ifdef REGISTRO_DECODIFICACION_CONTADOR_EN
    .num_inst(num_inst),
`endif
    .ilegal(ilegal)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [2:0]  tipo;
    logic        usa;
    logic        ileg;
  } exp_t;
  exp_t q[$];
  exp_t cur, e;
  int checks = 0, errors = 0, cuenta = 0;
  logic held_v = 0;
  logic [31:0] held_inst = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    if (held_v) chk("hold_inst", inst_sal, held_inst);
    held_v = rst_n && !vaciar && valido_sal && !listo_sal;
    held_inst = inst_sal;
    if (valido_sal && listo_sal) begin
      if (q.size() == 0) chk("extra_out", q.size(), 1);
      else begin
        e = q.pop_front();
        chk("out_inst", inst_sal, e.inst);
        chk("out_pc", pc_sal, e.pc);
        chk("out_tipo", {29'd0, tipo}, {29'd0, e.tipo});
        chk("out_usa", {31'd0, usa_inmediato}, {31'd0, e.usa});
        chk("out_ilegal", {31'd0, ilegal}, {31'd0, e.ileg});
        cuenta++;
      end
    end
    if (!rst_n || vaciar) q.delete();
    else if (valido_ent && listo_ent) q.push_back(cur);
    @(posedge clk);
    #1;
  endtask
  task automatic offer(input logic [31:0] i, input logic [31:0] pc, input logic [2:0] t,
                       input logic u, input logic il);
    cur = '{i, pc, t, u, il};
    inst_ent = i;
    pc_ent = pc;
    valido_ent = 1;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_valido"}, {31'd0, valido_sal}, 0);
    chk({tag, "_inst"}, inst_sal, 32'h00000013);
    chk({tag, "_pc"}, pc_sal, 0);
    chk({tag, "_tipo"}, {29'd0, tipo}, 0);
    chk({tag, "_usa"}, {31'd0, usa_inmediato}, 0);
    chk({tag, "_ilegal"}, {31'd0, ilegal}, 0);
`ifdef REGISTRO_DECODIFICACION_CONTADOR_EN
    chk({tag, "_num_inst"}, num_inst, 0);
`endif
  endtask
  logic [31:0] ti[11] = '{32'h7C102823, 32'h00208463, 32'h00064037, 32'h0080006F, 32'h002081B3,
                          32'h00000097, 32'h00002083, 32'h000080E7, 32'h0000000F, 32'h00000073,
                          32'h00000091};
  logic [2:0] tt[11] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
  logic tu[11] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 0};
  logic tl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
  initial begin
    #1;
    cyc();
    cyc();
    chk("rst_listo", {31'd0, listo_ent}, 0);
    chk_reset("rst");
    rst_n = 1;
    cyc();
    chk("rel_listo", {31'd0, listo_ent}, 1);
    offer(32'h7D000093, 32'h100, 3'd0, 1, 0);
    cyc();
    valido_ent = 0;
    chk("lat_valido", {31'd0, valido_sal}, 1);
    chk("lat_tipo", {29'd0, tipo}, 0);
    chk("lat_usa", {31'd0, usa_inmediato}, 1);
    chk("lat_pc", pc_sal, 32'h100);
    listo_sal = 1;
    cyc();
    for (int i = 0; i < 11; i++) begin
      offer(ti[i], 32'h200 + 4 * i, tt[i], tu[i], tl[i]);
      cyc();
      chk("stream_valido", {31'd0, valido_sal}, 1);
    end
    valido_ent = 0;
    cyc();
    chk("stream_end", {31'd0, valido_sal}, 0);
    listo_sal = 0;
    offer(32'h00100093, 32'h300, 3'd0, 1, 0);
    cyc();
    offer(32'h00200113, 32'h304, 3'd0, 1, 0);
    cyc();
    chk("bp_listo_b", {31'd0, listo_ent}, 0);
    offer(32'h00300193, 32'h308, 3'd0, 1, 0);
    cyc();
    cyc();
    chk("bp_listo_c", {31'd0, listo_ent}, 0);
    chk("bp_hold_a", inst_sal, 32'h00100093);
    listo_sal = 1;
    cyc();
    chk("bp_listo_back", {31'd0, listo_ent}, 1);
    cyc();
    valido_ent = 0;
    cyc();
    chk("bp_drained", q.size(), 0);
    listo_sal = 0;
    offer(32'h00400213, 32'h400, 3'd0, 1, 0);
    cyc();
    offer(32'h00500293, 32'h404, 3'd0, 1, 0);
    cyc();
    offer(32'h00600313, 32'h408, 3'd0, 1, 0);
    vaciar = 1;
    cyc();
    vaciar = 0;
    valido_ent = 0;
    chk("fl_valido", {31'd0, valido_sal}, 0);
    chk("fl_inst", inst_sal, 32'h00000013);
    chk("fl_listo", {31'd0, listo_ent}, 1);
    listo_sal = 1;
    repeat (3) cyc();
    chk("fl_empty", {31'd0, valido_sal}, 0);
    offer(32'h00000000, 32'h500, 3'd0, 0, 1);
    cyc();
    offer(32'hFFFFFFFF, 32'h504, 3'd0, 0, 1);
    cyc();
    valido_ent = 0;
    cyc();
    chk("il_drained", q.size(), 0);
`ifdef REGISTRO_DECODIFICACION_CONTADOR_EN
    chk("cnt_total", num_inst, cuenta);
`endif
    listo_sal = 0;
    offer(32'h00700393, 32'h600, 3'd0, 1, 0);
    cyc();
    offer(32'h00800413, 32'h604, 3'd0, 1, 0);
    cyc();
    chk("rm_listo_full", {31'd0, listo_ent}, 0);
    rst_n = 0;
    valido_ent = 0;
    cyc();
    cuenta = 0;
    chk("rm_listo", {31'd0, listo_ent}, 0);
    chk_reset("rm");
    rst_n = 1;
    cyc();
    chk("rm_rel_listo", {31'd0, listo_ent}, 1);
    chk("rm_rel_valido", {31'd0, valido_sal}, 0);
    listo_sal = 1;
    repeat (2) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/registro_decodificacion.md
Name: registro_decodificacion

Overview:
- Pipeline register between instruction fetch and the immediate decoder (valor_inmediato).
- Accepts fetched instruction + PC over a valid/ready handshake and buffers them in a 2-entry skid buffer.
- Classifies the RV32I opcode into the 3-bit immediate type consumed by valor_inmediato. Flags instructions that use no immediate, and illegal encodings.

Parameters:
- ANCHO_PC, 32, width of the PC carried alongside each instruction.
- INST_NOP, 32'h00000013, value driven on inst_sal after reset and after flush (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- valido_ent  in  1  fetch presents a valid instruction.
- listo_ent  out  1  block can accept an instruction this cycle.
- inst_ent  in  32  fetched instruction.
- pc_ent  in  ANCHO_PC  PC of inst_ent.
- vaciar  in  1  flush (branch taken / exception); discards all buffered entries.
- valido_sal  out  1  output entry valid.
- listo_sal  in  1  downstream accepts the output entry.
- inst_sal  out  32  buffered instruction, fed to valor_inmediato.inst.
- pc_sal  out  ANCHO_PC  PC of inst_sal.
- tipo  out  3  immediate type: 000 I, 001 S, 010 B, 011 U, 100 J; feeds valor_inmediato.tipo.
- usa_inmediato  out  1  instruction carries an immediate.
- ilegal  out  1  opcode not RV32I, or inst[1:0] != 2'b11.

Behaviour:
- Reset (rst_n=0 at a clock edge) has priority over everything else:
  - valido_sal=0, listo_ent=0, inst_sal=INST_NOP, pc_sal=0, tipo=000, usa_inmediato=0, ilegal=0.
  - Skid entry is invalidated.
  - listo_ent rises at the first edge with rst_n=1.
- Handshakes:
  - An input transfer occurs when valido_ent & listo_ent.
  - An output transfer occurs when valido_sal & listo_sal.
- Decode is performed on inst_ent and registered with the entry (no combinational path from inst_ent to tipo). Opcode inst[6:0] maps as:
  - 0000011 load, 0010011 op-imm, 1100111 jalr, 0001111 fence, 1110011 system → tipo 000, usa 1.
  - 0100011 store → tipo 001, usa 1.
  - 1100011 branch → tipo 010, usa 1.
  - 0110111 lui, 0010111 auipc → tipo 011, usa 1.
  - 1101111 jal → tipo 100, usa 1.
  - 0110011 op → tipo 000, usa 0.
  - Any other value, or inst[1:0] != 11 → tipo 000, usa 0, ilegal 1.
- Latency: 1 cycle from input transfer to valido_sal when the buffer is empty. Throughput is 1 per cycle while listo_sal=1.
- Skid buffer holds 2 entries: the output register plus one skid register.
- listo_ent is registered:
  - 1 when the skid register is empty.
  - 0 when the skid register is full.
- Input accepted while the output is stalled (valido_sal & !listo_sal) goes to the skid register. listo_ent drops on the next edge.
- On an output transfer with the skid full, the skid entry moves to the output register. listo_ent returns to 1 on the same edge.
- While valido_sal=1 and listo_sal=0, inst_sal/pc_sal/tipo/usa_inmediato/ilegal must hold stable.
- Simultaneous input and output transfer with the skid empty: the new entry replaces the output; valido_sal stays 1.
- Flush: vaciar=1 at an edge (rst_n=1):
  - Both entries are invalidated and any input transferred in that same cycle is discarded.
  - valido_sal=0 and inst_sal=INST_NOP next cycle; listo_ent=1 next cycle.
  - vaciar has priority over handshakes.
- An illegal instruction is still passed through with ilegal=1. The block never blocks on it.
- Order is strictly FIFO. No entry is ever duplicated or dropped except by flush or reset.

Optional Feature:
- Macro: REGISTRO_DECODIFICACION_CONTADOR_EN.
- Defined:
  - Adds output num_inst [31:0], the count of output transfers.
  - Reset value 0; wraps 32'hFFFFFFFF → 0.
  - Not cleared by vaciar; increments on the edge of each output transfer.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset then single instruction: inst_ent=32'h7D000093 (addi x1,x0,2000), pc=0x100 → one cycle later valido_sal=1, tipo=000, usa=1, ilegal=0, pc_sal=0x100. Chained valor_inmediato yields 2000.
- Type coverage, one per cycle with listo_sal=1: sw (0x7C102823), beq (opcode 1100011), lui 0x00064037, jal (opcode 1101111), add 0x002081B3 → tipo 001, 010, 011, 100, then 000 with usa=0. One output per cycle, in order.
- Backpressure: listo_sal=0 with 3 instructions A, B, C offered → A held on output, B in skid, listo_ent=0, C not taken. listo_sal=1 → A, B, C emerge in order with no loss.
- Flush: buffer full (A on output, B in skid), vaciar=1 while valido_ent=1 with C → next cycle valido_sal=0, inst_sal=0x00000013, listo_ent=1. A, B, C never appear.
- Illegal: inst_ent=32'h00000000 and 32'hFFFFFFFF → ilegal=1, usa=0, passed through normally.
- Reset mid-stall: buffer full, rst_n=0 for 1 cycle → all outputs at reset values. listo_ent=1 on the first edge after release. With the macro defined, num_inst=0.
